uart_cmd_ctrl: RTL and testbench
================================

Name: uart_cmd_ctrl

Overview:
Byte-level command controller between uart_rx and a uart_tx transmitter in the top-level FPGA design. Parses a 2/3-byte register read/write protocol from received bytes, executes it against a 4-entry 8-bit register file, and queues a 1-byte response over a valid/ready handshake to the transmitter. Register 0 drives the board LEDs; register 3 is a read-only count of received bytes.

Parameters:
TimeoutCycles, 26_040, max i_clk cycles allowed between bytes of one frame (~30 byte times at 10 MHz/115200); counter width derived as a localparam via $clog2.
LedResetVal, 4'h0, reset value of reg0[3:0].

Ports:
i_clk  input  1  system clock
i_rst_n  input  1  asynchronous active-low reset
i_rx_valid  input  1  single-cycle strobe: i_rx_byte is valid
i_rx_byte  input  8  received byte
o_tx_valid  output  1  response byte available
o_tx_byte  output  8  response byte
i_tx_ready  input  1  transmitter accepts byte when high with o_tx_valid
o_led  output  4  reg0[3:0]
o_busy  output  1  high in any state except IDLE
o_timeout  output  1  1-cycle pulse on frame abort
o_overrun  output  1  1-cycle pulse when a byte is dropped

Behaviour:
- Reset (async assert, sync release on i_clk): state IDLE; reg0=LedResetVal (upper nibble 0), reg1=reg2=0, rx count=0; o_tx_valid=0, o_tx_byte=0, o_busy=0, o_timeout=0, o_overrun=0, o_led=LedResetVal. Reset mid-frame or mid-response drops everything immediately; no partial write.
- Frame: byte0 cmd ('W'=0x57, 'R'=0x52); byte1 addr (valid 0x00..0x03); byte2 data (W only).
- States: IDLE -> GET_ADDR on any byte. GET_ADDR -> GET_DATA (cmd W) or EXEC (cmd R) on byte. Unknown cmd: IDLE -> EXEC directly, response '?'. GET_DATA -> EXEC on byte. EXEC -> RESP after one cycle. RESP -> IDLE on o_tx_valid && i_tx_ready.
- EXEC (1 cycle): write reg[addr]=data if addr in 0..2 -> response 'K' (0x4B); addr 3 or addr > 3 -> no write, '?' (0x3F). Read addr 0..3 -> reg value; addr > 3 -> '?'. Bad write address still consumes the data byte (framing preserved).
- Latency: final byte strobed in cycle N -> EXEC in N+1 (write lands end of N+1) -> o_tx_valid high from N+2; o_led reflects write from N+2.
- TX handshake: o_tx_valid stays high and o_tx_byte stable until i_tx_ready sampled high; then o_tx_valid low next cycle. i_tx_ready high on the first RESP cycle completes the response in that cycle.
- rx count (reg3): +1 on every i_rx_valid including dropped bytes, wraps 0xFF -> 0x00. A read of reg3 returns the value sampled in EXEC.
- Timeout: counter cleared on each accepted byte, counts only in GET_ADDR/GET_DATA; reaching TimeoutCycles-1 -> IDLE, o_timeout pulse, no response. Byte arriving in the expiry cycle wins: accepted, no timeout.
- Bytes arriving in EXEC or RESP are dropped, o_overrun pulses; state unaffected.
- o_busy = (state != IDLE), registered with the state.

Decomposition:
- Package uart_cmd_pkg: command codes (CMD_WR=0x57, CMD_RD=0x52), response codes (RSP_OK=0x4B, RSP_ERR=0x3F), register address constants (REG_LED=0..REG_RXCNT=3), state enum (IDLE, GET_ADDR, GET_DATA, EXEC, RESP).
- Sub-module uart_cmd_regfile: 4x8 register file with write enable, read mux, reg3 wrapping counter input; the FSM, timeout counter and TX holding register stay in uart_cmd_ctrl.

Test Plan:
- Write LED: bytes 0x57,0x00,0x05 with i_tx_ready=1 -> o_tx_byte=0x4B valid 2 cycles after last byte; o_led=4'h5 from that cycle.
- Readback with backpressure: 0x57,0x01,0xA5 then 0x52,0x01 with i_tx_ready=0 for 20 cycles -> o_tx_valid held, o_tx_byte=0xA5 stable, cleared 1 cycle after ready rises.
- Errors: 0x52,0x07 -> 0x3F; 0x57,0x03,0x11 -> 0x3F, reg3 unchanged; 0x41 alone -> 0x3F, IDLE after response.
- Timeout: 0x52 then silence TimeoutCycles -> o_timeout single pulse, o_busy=0, no o_tx_valid; next 0x52,0x00 read succeeds normally.
- Overrun/counter: byte during RESP -> o_overrun pulse, response unchanged; after reset, 3 frames totalling 8 bytes plus read 0x52,0x03 -> response 0x0A; 256 more bytes -> wrap verified.
- Reset mid-frame: assert i_rst_n=0 after 0x57,0x00 -> all outputs at reset values immediately; o_led=LedResetVal; subsequent 0x05 byte treated as new cmd -> 0x3F.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared constants and types for the UART register command controller.
package uart_cmd_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned REG_AW = 2;
  localparam int unsigned LED_W  = 4;

  localparam logic [DATA_W-1:0] CMD_WR  = 8'h57;
  localparam logic [DATA_W-1:0] CMD_RD  = 8'h52;
  localparam logic [DATA_W-1:0] RSP_OK  = 8'h4B;
  localparam logic [DATA_W-1:0] RSP_ERR = 8'h3F;

  localparam logic [REG_AW-1:0] REG_LED   = 2'd0;
  localparam logic [REG_AW-1:0] REG_USR1  = 2'd1;
  localparam logic [REG_AW-1:0] REG_USR2  = 2'd2;
  localparam logic [REG_AW-1:0] REG_RXCNT = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
    EXEC,
    RESP
  } state_e;

endpackage

// File: rtl/uart_cmd_regfile.sv
// 4x8 register file: three writable registers plus a free-running received-byte counter.
module uart_cmd_regfile
  import uart_cmd_pkg::*;
#(
  parameter logic [LED_W-1:0] LedResetVal = 4'h0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr_en,
  input  logic [REG_AW-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_cnt_inc,
  input  logic [REG_AW-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data,
  output logic [LED_W-1:0]  o_led
);

  logic [DATA_W-1:0] reg0_q, reg0_d;
  logic [DATA_W-1:0] reg1_q, reg1_d;
  logic [DATA_W-1:0] reg2_q, reg2_d;
  logic [DATA_W-1:0] cnt_q,  cnt_d;

  // Next-state for writable registers and the wrapping byte counter.
  always_comb begin
    reg0_d = reg0_q;
    reg1_d = reg1_q;
    reg2_d = reg2_q;
    cnt_d  = cnt_q;
    if (i_wr_en) begin
      case (i_wr_addr)
        REG_LED:  reg0_d = i_wr_data;
        REG_USR1: reg1_d = i_wr_data;
        REG_USR2: reg2_d = i_wr_data;
        default:  ;
      endcase
    end
    if (i_cnt_inc) cnt_d = cnt_q + DATA_W'(1);
  end

  // Register storage.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      reg0_q <= {{(DATA_W-LED_W){1'b0}}, LedResetVal};
      reg1_q <= '0;
      reg2_q <= '0;
      cnt_q  <= '0;
    end else begin
      reg0_q <= reg0_d;
      reg1_q <= reg1_d;
      reg2_q <= reg2_d;
      cnt_q  <= cnt_d;
    end
  end

  // Read mux; the counter occupies the last address.
  always_comb begin
    case (i_rd_addr)
      REG_LED:  o_rd_data = reg0_q;
      REG_USR1: o_rd_data = reg1_q;
      REG_USR2: o_rd_data = reg2_q;
      default:  o_rd_data = cnt_q;
    endcase
  end

  assign o_led = reg0_q[LED_W-1:0];

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Parses 'W'/'R' register frames from the UART receiver and returns a 1-byte response.
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int unsigned      TimeoutCycles = 26_040,
  parameter logic [LED_W-1:0] LedResetVal   = 4'h0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_rx_valid,
  input  logic [DATA_W-1:0] i_rx_byte,
  output logic              o_tx_valid,
  output logic [DATA_W-1:0] o_tx_byte,
  input  logic              i_tx_ready,
  output logic [LED_W-1:0]  o_led,
  output logic              o_busy,
  output logic              o_timeout,
  output logic              o_overrun
);

  localparam int unsigned TMO_W = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TimeoutCycles - 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] cmd_q, cmd_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic              tx_valid_q, tx_valid_d;
  logic [DATA_W-1:0] tx_byte_q, tx_byte_d;
  logic              busy_q, busy_d;
  logic              timeout_q, timeout_d;
  logic              overrun_q, overrun_d;
  logic              wr_en_c;
  logic [DATA_W-1:0] rd_data_c;

  uart_cmd_regfile #(
    .LedResetVal(LedResetVal)
  ) u_regfile (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_wr_en  (wr_en_c),
    .i_wr_addr(addr_q[REG_AW-1:0]),
    .i_wr_data(data_q),
    .i_cnt_inc(i_rx_valid),
    .i_rd_addr(addr_q[REG_AW-1:0]),
    .o_rd_data(rd_data_c),
    .o_led    (o_led)
  );

  // Frame parsing, inter-byte timeout, execution and response handshake.
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    data_d     = data_q;
    tmo_cnt_d  = '0;
    tx_valid_d = tx_valid_q;
    tx_byte_d  = tx_byte_q;
    timeout_d  = 1'b0;
    overrun_d  = 1'b0;
    wr_en_c    = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_rx_valid) begin
          cmd_d = i_rx_byte;
          // Unknown commands skip straight to EXEC so they are answered with '?'.
          if (i_rx_byte == CMD_WR || i_rx_byte == CMD_RD) state_d = GET_ADDR;
          else                                            state_d = EXEC;
        end
      end
      GET_ADDR: begin
        if (i_rx_valid) begin
          addr_d  = i_rx_byte;
          state_d = (cmd_q == CMD_WR) ? GET_DATA : EXEC;
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end
      GET_DATA: begin
        if (i_rx_valid) begin
          data_d  = i_rx_byte;
          state_d = EXEC;
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end
      EXEC: begin
        overrun_d  = i_rx_valid;
        tx_valid_d = 1'b1;
        state_d    = RESP;
        tx_byte_d  = RSP_ERR;
        if (cmd_q == CMD_WR) begin
          // The counter register is read-only; only 0..2 accept writes.
          if (addr_q <= DATA_W'(REG_USR2)) begin
            wr_en_c   = 1'b1;
            tx_byte_d = RSP_OK;
          end
        end else if (cmd_q == CMD_RD) begin
          if (addr_q <= DATA_W'(REG_RXCNT)) tx_byte_d = rd_data_c;
        end
      end
      RESP: begin
        overrun_d = i_rx_valid;
        if (tx_valid_q && i_tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      cmd_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      tmo_cnt_q  <= '0;
      tx_valid_q <= 1'b0;
      tx_byte_q  <= '0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      tmo_cnt_q  <= tmo_cnt_d;
      tx_valid_q <= tx_valid_d;
      tx_byte_q  <= tx_byte_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
      overrun_q  <= overrun_d;
    end
  end

  assign o_tx_valid = tx_valid_q;
  assign o_tx_byte  = tx_byte_q;
  assign o_busy     = busy_q;
  assign o_timeout  = timeout_q;
  assign o_overrun  = overrun_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Scoreboard bench for uart_cmd_ctrl: expected responses queued at stimulus, compared at handshake.
module tb_uart_cmd_ctrl;

  localparam int unsigned T   = 64;
  localparam logic [3:0]  LRV = 4'h6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       tx_ready = 1'b1;
  logic       o_tx_valid;
  logic [7:0] o_tx_byte;
  logic [3:0] o_led;
  logic       o_busy, o_timeout, o_overrun;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rx_cnt_m = 8'h00;

  uart_cmd_ctrl #(.TimeoutCycles(T), .LedResetVal(LRV)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_rx_valid(rx_valid),
    .i_rx_byte (rx_byte),
    .o_tx_valid(o_tx_valid),
    .o_tx_byte (o_tx_byte),
    .i_tx_ready(tx_ready),
    .o_led     (o_led),
    .o_busy    (o_busy),
    .o_timeout (o_timeout),
    .o_overrun (o_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Response monitor: pop and compare on each accepted byte, flag unexpected ones.
  always @(negedge clk) begin
    if (rst_n && o_tx_valid) begin
      if (exp_q.size() == 0) chk("spurious_tx", 32'(o_tx_byte), 32'hFFFF_FFFF);
      else if (tx_ready) chk("tx_byte", 32'(o_tx_byte), 32'(exp_q.pop_front()));
    end
  end

  // Drive a byte in the current cycle, return one cycle later.
  task automatic drive_now(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    rx_cnt_m = rx_cnt_m + 8'd1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    drive_now(b);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (!o_busy && !o_tx_valid && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_txv"},  32'(o_tx_valid), 32'd0);
    chk({tag, "_txb"},  32'(o_tx_byte),  32'd0);
    chk({tag, "_busy"}, 32'(o_busy),     32'd0);
    chk({tag, "_tmo"},  32'(o_timeout),  32'd0);
    chk({tag, "_ovr"},  32'(o_overrun),  32'd0);
    chk({tag, "_led"},  32'(o_led),      32'(LRV));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    exp_q.delete();
    rx_cnt_m = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int seen;

  initial begin
    do_reset();

    // Write LED register with latency checks.
    tx_ready = 1'b1;
    exp_q.push_back(8'h4B);
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h05);
    chk("wr_exec_txv",  32'(o_tx_valid), 32'd0);
    chk("wr_exec_busy", 32'(o_busy),     32'd1);
    chk("wr_exec_led",  32'(o_led),      32'(LRV));
    @(posedge clk); #1;
    chk("wr_resp_txv", 32'(o_tx_valid), 32'd1);
    chk("wr_resp_txb", 32'(o_tx_byte),  32'h4B);
    chk("wr_resp_led", 32'(o_led),      32'h5);
    wait_idle();

    // Readback under backpressure, plus an overrun byte during RESP.
    exp_q.push_back(8'h4B);
    send_byte(8'h57); send_byte(8'h01); send_byte(8'hA5);
    wait_idle();
    tx_ready = 1'b0;
    exp_q.push_back(8'hA5);
    send_byte(8'h52); send_byte(8'h01);
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) begin
      chk("bp_txv", 32'(o_tx_valid), 32'd1);
      chk("bp_txb", 32'(o_tx_byte),  32'hA5);
      @(posedge clk); #1;
    end
    drive_now(8'h33);
    chk("ovr_pulse", 32'(o_overrun),  32'd1);
    chk("ovr_txv",   32'(o_tx_valid), 32'd1);
    chk("ovr_txb",   32'(o_tx_byte),  32'hA5);
    @(posedge clk); #1;
    chk("ovr_end", 32'(o_overrun), 32'd0);
    tx_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_clear_txv",  32'(o_tx_valid), 32'd0);
    chk("bp_clear_busy", 32'(o_busy),     32'd0);

    // Error responses.
    exp_q.push_back(8'h3F);
    send_byte(8'h52); send_byte(8'h07);
    wait_idle();
    exp_q.push_back(8'h3F);
    send_byte(8'h57); send_byte(8'h03); send_byte(8'h11);
    wait_idle();
    exp_q.push_back(rx_cnt_m + 8'd2);
    send_byte(8'h52); send_byte(8'h03);
    wait_idle();
    exp_q.push_back(8'h3F);
    send_byte(8'h41);
    wait_idle();
    chk("unk_idle", 32'(o_busy), 32'd0);

    // Timeout after a lone command byte.
    send_byte(8'h52);
    seen = 0;
    for (int i = 1; i <= int'(T) + 20; i++) begin
      @(posedge clk); #1;
      if (o_timeout) begin
        seen = i;
        break;
      end
    end
    chk("tmo_cycle", 32'(seen), 32'(T));
    chk("tmo_busy", 32'(o_busy), 32'd0);
    @(posedge clk); #1;
    chk("tmo_single", 32'(o_timeout), 32'd0);
    exp_q.push_back(8'h05);
    send_byte(8'h52); send_byte(8'h00);
    wait_idle();

    // Byte arriving exactly in the expiry cycle is accepted.
    exp_q.push_back(8'h05);
    send_byte(8'h52);
    repeat (T - 1) @(posedge clk);
    #1;
    drive_now(8'h00);
    chk("tmo_race_tmo", 32'(o_timeout), 32'd0);
    chk("tmo_race_busy", 32'(o_busy), 32'd1);
    wait_idle();

    // Byte counter after reset: 8 bytes of frames then read reg3 -> 0x0A.
    do_reset();
    exp_q.push_back(8'h4B);
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h05);
    wait_idle();
    exp_q.push_back(8'h4B);
    send_byte(8'h57); send_byte(8'h01); send_byte(8'h22);
    wait_idle();
    exp_q.push_back(8'h22);
    send_byte(8'h52); send_byte(8'h01);
    wait_idle();
    exp_q.push_back(8'h0A);
    send_byte(8'h52); send_byte(8'h03);
    wait_idle();
    for (int i = 0; i < 256; i++) begin
      exp_q.push_back(8'h3F);
      send_byte(8'h41);
      wait_idle();
    end
    exp_q.push_back(rx_cnt_m + 8'd2);
    send_byte(8'h52); send_byte(8'h03);
    wait_idle();
    chk("cnt_wrap_model", 32'(rx_cnt_m), 32'h0C);

    // Reset mid-frame drops the frame; next byte starts a new frame.
    send_byte(8'h57); send_byte(8'h00);
    chk("mid_busy_pre", 32'(o_busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid");
    exp_q.delete();
    rx_cnt_m = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(8'h3F);
    send_byte(8'h05);
    wait_idle();
    chk("mid_led_after", 32'(o_led), 32'(LRV));

    repeat (5) @(posedge clk);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
